// File: rtl/rom_ctrl_data_sink.sv
// rom_ctrl_data_sink: consumer end of the ROM checker data stream.
// Forwards non-top ROM words to KMAC via a one-entry register, captures the top words as the expected digest.
// Ports: data_* (ROM word in, vld/rdy), kmac_* (message out, valid/ready), exp_* (digest out), err_o (sticky error).
// Latency: one cycle from accepted ROM word to kmac_valid_o; full throughput when KMAC is ready.
// Backpressure: while hashing, data_rdy_o follows buffer space / kmac_ready_i; top words are always accepted.
module rom_ctrl_data_sink #(
   parameter  int DataWidth   = 40,
   parameter  int RomDepth    = 16,
   parameter  int RomTopCount = 2,
   localparam int AW          = $clog2(RomDepth)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             data_vld_i,
   input  logic [DataWidth-1:0]             data_i,
   input  logic [AW-1:0]                    data_addr_i,
   input  logic                             data_last_nontop_i,
   output logic                             data_rdy_o,
   output logic                             kmac_valid_o,
   output logic [DataWidth-1:0]             kmac_data_o,
   output logic                             kmac_last_o,
   input  logic                             kmac_ready_i,
   output logic [RomTopCount*DataWidth-1:0] exp_digest_o,
   output logic                             exp_valid_o,
   output logic                             err_o
);

   localparam logic [AW-1:0] TopBase    = AW'(RomDepth - RomTopCount);
   localparam logic [AW-1:0] LastNonTop = AW'(RomDepth - RomTopCount - 1);
   localparam logic [AW-1:0] AddrMax    = AW'(RomDepth - 1);

   typedef enum logic [1:0] {StHash, StTop, StDone, StError} state_e;

   state_e                           state_q;
   logic [AW-1:0]                    exp_addr_q;
   logic [AW-1:0]                    exp_addr_d;
   logic [DataWidth-1:0]             buf_q;
   logic                             buf_last_q;
   logic                             buf_full_q;
   logic [RomTopCount*DataWidth-1:0] digest_q;

   logic          accept;
   logic          kmac_hs;
   logic          addr_err;
   logic          flag_err;
   logic          seq_err;
   logic [AW-1:0] top_slot;

   always_comb begin
      data_rdy_o = 1'b0;
      unique case (state_q)
         StHash:  data_rdy_o = ~buf_full_q | kmac_ready_i;
         StTop:   data_rdy_o = 1'b1;
         default: data_rdy_o = 1'b0;
      endcase
      // Nothing may be accepted while reset is held, so ready stays low with the other outputs.
      if (rst_i) data_rdy_o = 1'b0;
   end

   assign accept     = data_vld_i & data_rdy_o;
   assign exp_addr_d = exp_addr_q + AW'(1);
   assign top_slot   = data_addr_i - TopBase;

   // The last-word flag must be set exactly on the last non-top address while hashing,
   // and never on a top word.
   assign addr_err = (data_addr_i != exp_addr_q);
   assign flag_err = (state_q == StHash) ? (data_last_nontop_i != (data_addr_i == LastNonTop))
                                         : data_last_nontop_i;
   assign seq_err  = addr_err | flag_err;

   // A pending word is hidden from KMAC once an error is flagged.
   assign kmac_valid_o = buf_full_q & (state_q != StError);
   assign kmac_last_o  = kmac_valid_o & buf_last_q;
   assign kmac_data_o  = buf_q;
   assign kmac_hs      = kmac_valid_o & kmac_ready_i;

   assign exp_digest_o = digest_q;
   assign exp_valid_o  = (state_q == StDone) & ~buf_full_q;
   assign err_o        = (state_q == StError);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StHash;
         exp_addr_q <= '0;
         buf_q      <= '0;
         buf_last_q <= 1'b0;
         buf_full_q <= 1'b0;
         digest_q   <= '0;
      end else begin
         // Drain first; a same-cycle refill below overrides the clear.
         if (kmac_hs) buf_full_q <= 1'b0;

         if (accept) begin
            if (seq_err) begin
               state_q <= StError;
            end else if (state_q == StHash) begin
               buf_q      <= data_i;
               buf_last_q <= data_last_nontop_i;
               buf_full_q <= 1'b1;
               exp_addr_q <= exp_addr_d;
               if (data_last_nontop_i) state_q <= StTop;
            end else begin
               for (int k = 0; k < RomTopCount; k++) begin
                  if (top_slot == AW'(k)) digest_q[k*DataWidth +: DataWidth] <= data_i;
               end
               // Hold the counter at the top address so it never wraps.
               if (data_addr_i == AddrMax) state_q <= StDone;
               else                        exp_addr_q <= exp_addr_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_ctrl_data_sink.sv
module tb_rom_ctrl_data_sink;

   localparam int DW      = 40;
   localparam int DEPTH   = 16;
   localparam int TOP     = 2;
   localparam int AW      = 4;
   localparam int TOPBASE = DEPTH - TOP;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                data_vld_i = 1'b0;
   logic [DW-1:0]       data_i = '0;
   logic [AW-1:0]       data_addr_i = '0;
   logic                data_last_nontop_i = 1'b0;
   logic                data_rdy_o;
   logic                kmac_valid_o;
   logic [DW-1:0]       kmac_data_o;
   logic                kmac_last_o;
   logic                kmac_ready_i = 1'b1;
   logic [TOP*DW-1:0]   exp_digest_o;
   logic                exp_valid_o;
   logic                err_o;

   int checks = 0;
   int errors = 0;
   int kmac_cnt = 0;
   logic [DW:0]   sb[$];
   logic [DW-1:0] words[DEPTH];

   rom_ctrl_data_sink #(.DataWidth(DW), .RomDepth(DEPTH), .RomTopCount(TOP)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_vld_i(data_vld_i), .data_i(data_i),
      .data_addr_i(data_addr_i), .data_last_nontop_i(data_last_nontop_i),
      .data_rdy_o(data_rdy_o), .kmac_valid_o(kmac_valid_o), .kmac_data_o(kmac_data_o),
      .kmac_last_o(kmac_last_o), .kmac_ready_i(kmac_ready_i), .exp_digest_o(exp_digest_o),
      .exp_valid_o(exp_valid_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: the front entry must be on the KMAC port whenever it is valid; pop on handshake.
   always @(negedge clk_i) begin
      if (!rst_i && kmac_valid_o) begin
         if (sb.size() == 0) begin
            chk("kmac_unexpected", 1, 0);
         end else begin
            chk("kmac_data", kmac_data_o, sb[0][DW-1:0]);
            chk("kmac_last", kmac_last_o, sb[0][DW]);
            if (kmac_ready_i) begin
               void'(sb.pop_front());
               kmac_cnt++;
            end
         end
      end
   end

   task automatic offer(input int a, input bit last, input bit push);
      int n = 0;
      words[a] = {8'(a), 32'($urandom)};
      data_vld_i = 1'b1;
      data_addr_i = AW'(a);
      data_i = words[a];
      data_last_nontop_i = last;
      forever begin
         @(negedge clk_i);
         if (data_rdy_o) break;
         n++;
         if (n > 200) begin
            chk("rdy_timeout", 0, 1);
            break;
         end
      end
      if (data_rdy_o && push && a < TOPBASE) sb.push_back({last, words[a]});
      @(posedge clk_i);
      #1;
      data_vld_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      data_vld_i = 1'b0;
      kmac_ready_i = 1'b1;
      sb.delete();
      kmac_cnt = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst_rdy", data_rdy_o, 1);
      chk("rst_kvalid", kmac_valid_o, 0);
      chk("rst_expvalid", exp_valid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_digest", exp_digest_o, 0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_full(input string tag);
      for (int a = 0; a < DEPTH; a++) offer(a, a == TOPBASE - 1, 1'b1);
      @(negedge clk_i);
      chk({tag, "_expvalid"}, exp_valid_o, 1);
      chk({tag, "_digest"}, exp_digest_o, {words[15], words[14]});
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_kcount"}, kmac_cnt, TOPBASE);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_rdy_done"}, data_rdy_o, 0);
   endtask

   task automatic check_error_hold(input string tag);
      repeat (4) begin
         @(negedge clk_i);
         chk({tag, "_err"}, err_o, 1);
         chk({tag, "_rdy"}, data_rdy_o, 0);
         chk({tag, "_kvalid"}, kmac_valid_o, 0);
         chk({tag, "_expvalid"}, exp_valid_o, 0);
      end
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Streaming at full rate.
      do_reset();
      run_full("stream");

      // KMAC backpressure while addresses 3 and 4 are offered.
      do_reset();
      for (int a = 0; a < 4; a++) offer(a, 1'b0, 1'b1);
      kmac_ready_i = 1'b0;
      words[4] = {8'(4), 32'($urandom)};
      data_vld_i = 1'b1;
      data_addr_i = AW'(4);
      data_i = words[4];
      data_last_nontop_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         chk("bp_rdy", data_rdy_o, 0);
         chk("bp_hold", kmac_data_o, words[3]);
         @(posedge clk_i);
         #1;
      end
      kmac_ready_i = 1'b1;
      offer(4, 1'b0, 1'b1);
      for (int a = 5; a < DEPTH; a++) offer(a, a == TOPBASE - 1, 1'b1);
      @(negedge clk_i);
      chk("bp_kcount", kmac_cnt, TOPBASE);
      chk("bp_expvalid", exp_valid_o, 1);
      chk("bp_sb_empty", sb.size(), 0);

      // Top capture while KMAC stalls on address 13.
      do_reset();
      for (int a = 0; a < TOPBASE; a++) offer(a, a == TOPBASE - 1, 1'b1);
      kmac_ready_i = 1'b0;
      offer(14, 1'b0, 1'b1);
      offer(15, 1'b0, 1'b1);
      repeat (3) begin
         @(negedge clk_i);
         chk("stall_expvalid", exp_valid_o, 0);
         chk("stall_digest", exp_digest_o, {words[15], words[14]});
         chk("stall_kvalid", kmac_valid_o, 1);
      end
      @(posedge clk_i);
      #1;
      kmac_ready_i = 1'b1;
      @(negedge clk_i);
      chk("stall_expvalid_hs", exp_valid_o, 0);
      @(negedge clk_i);
      chk("stall_expvalid_after", exp_valid_o, 1);
      chk("stall_sb_empty", sb.size(), 0);

      // Address skip.
      do_reset();
      for (int a = 0; a < 4; a++) offer(a, 1'b0, 1'b1);
      offer(5, 1'b0, 1'b0);
      check_error_hold("skip");

      // Last flag set too early.
      do_reset();
      for (int a = 0; a < 12; a++) offer(a, 1'b0, 1'b1);
      offer(12, 1'b1, 1'b0);
      check_error_hold("early_last");

      // Last flag missing on address 13.
      do_reset();
      for (int a = 0; a < 13; a++) offer(a, 1'b0, 1'b1);
      offer(13, 1'b0, 1'b0);
      check_error_hold("missing_last");

      // Async reset with address 8 pending and address 9 offered.
      do_reset();
      for (int a = 0; a < 9; a++) offer(a, 1'b0, 1'b1);
      kmac_ready_i = 1'b0;
      data_vld_i = 1'b1;
      data_addr_i = AW'(9);
      data_i = 40'h09_1234_5678;
      @(posedge clk_i);
      #2;
      chk("pre_rst_kvalid", kmac_valid_o, 1);
      rst_i = 1'b1;
      sb.delete();
      #1;
      chk("arst_rdy", data_rdy_o, 0);
      chk("arst_kvalid", kmac_valid_o, 0);
      chk("arst_kdata", kmac_data_o, 0);
      chk("arst_klast", kmac_last_o, 0);
      chk("arst_expvalid", exp_valid_o, 0);
      chk("arst_err", err_o, 0);
      chk("arst_digest", exp_digest_o, 0);
      do_reset();
      run_full("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
